// File: rtl/sprite_rom_arbiter_if.sv
// Requester-side bus of the sprite ROM arbiter: level requests with addresses
// in, one-hot grant plus the registered one-hot response (rvalid/rdata) out.
interface sprite_rom_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int ADDR_W  = 11,
  parameter int DATA_W  = 5
);
  logic [NUM_REQ-1:0]        req;
  logic [NUM_REQ*ADDR_W-1:0] addr;
  logic [NUM_REQ-1:0]        gnt;
  logic [NUM_REQ-1:0]        rvalid;
  logic [DATA_W-1:0]         rdata;

  modport master (output req, output addr, input gnt, input rvalid, input rdata);
  modport slave  (input req, input addr, output gnt, output rvalid, output rdata);
endinterface

// File: rtl/sprite_rom_arbiter.sv
// Shares one sprite ROM read port among NUM_REQ mappers with a round-robin grant
// and a one-hot tag pipeline. SPRITE_ARB_FIXED_PRIO_EN selects fixed priority.
module sprite_rom_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ADDR_W  = 11,
  parameter int DATA_W  = 5,
  parameter int ROM_LAT = 1
) (
  input  logic                  vga_clk,
  input  logic                  reset,
  sprite_rom_arbiter_if.slave   bus,
  output logic [ADDR_W-1:0]     rom_address,
  input  logic [DATA_W-1:0]     rom_q
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  typedef logic [IDX_W-1:0] idx_t;

  logic [NUM_REQ-1:0] gnt_c;
  logic [ADDR_W-1:0]  addr_c;
  idx_t               gnt_idx;
  idx_t               cand;
  logic               found;

  logic [NUM_REQ-1:0] tag [ROM_LAT];
  logic [NUM_REQ-1:0] rvalid_q;
  logic [DATA_W-1:0]  rdata_q;

`ifndef SPRITE_ARB_FIXED_PRIO_EN
  idx_t last_idx;

  // Only granting cycles move the pointer, so idle gaps keep the rotation order.
  always_ff @(posedge vga_clk) begin
    if (reset) begin
      last_idx <= idx_t'(NUM_REQ - 1);
    end else if (found) begin
      last_idx <= gnt_idx;
    end
  end
`endif

  always_comb begin
    gnt_c   = '0;
    addr_c  = '0;
    gnt_idx = '0;
    cand    = '0;
    found   = 1'b0;
    if (!reset) begin
      for (int unsigned k = 0; k < NUM_REQ; k++) begin
`ifdef SPRITE_ARB_FIXED_PRIO_EN
        cand = idx_t'(k);
`else
        // Scan from last_idx+1 with a modulo wrap so non-power-of-two counts stay in range.
        cand = idx_t'((32'(last_idx) + k + 1) % NUM_REQ);
`endif
        if (!found && bus.req[cand]) begin
          found   = 1'b1;
          gnt_idx = cand;
        end
      end
      if (found) begin
        gnt_c[gnt_idx] = 1'b1;
        addr_c         = bus.addr[gnt_idx*ADDR_W +: ADDR_W];
      end
    end
  end

  always_ff @(posedge vga_clk) begin
    if (reset) begin
      for (int unsigned s = 0; s < ROM_LAT; s++) begin
        tag[s] <= '0;
      end
      rvalid_q <= '0;
      rdata_q  <= '0;
    end else begin
      tag[0] <= gnt_c;
      for (int unsigned s = 1; s < ROM_LAT; s++) begin
        tag[s] <= tag[s-1];
      end
      if (|tag[ROM_LAT-1]) begin
        rvalid_q <= tag[ROM_LAT-1];
        rdata_q  <= rom_q;
      end else begin
        rvalid_q <= '0;
      end
    end
  end

  assign bus.gnt     = gnt_c;
  assign bus.rvalid  = rvalid_q;
  assign bus.rdata   = rdata_q;
  assign rom_address = addr_c;

endmodule

// File: tb/tb_sprite_rom_arbiter.sv
// Directed bench for sprite_rom_arbiter with a one-cycle-latency ROM model
// whose word at address a is a[4:0] ^ 5'h0C (so word 37 = 9).
module tb_sprite_rom_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [10:0] rom_address;
  logic [4:0]  rom_q;
  logic [10:0] a_tab [4];
  int          errors = 0;
  int          checks = 0;

  sprite_rom_arbiter_if #(.NUM_REQ(4), .ADDR_W(11), .DATA_W(5)) bus ();

  sprite_rom_arbiter #(.NUM_REQ(4), .ADDR_W(11), .DATA_W(5), .ROM_LAT(1)) dut (
    .vga_clk     (clk),
    .reset       (rst),
    .bus         (bus),
    .rom_address (rom_address),
    .rom_q       (rom_q)
  );

  always #5 clk = ~clk;

  function automatic logic [4:0] rom_word(input logic [10:0] a);
    return a[4:0] ^ 5'h0C;
  endfunction

  always @(posedge clk) rom_q <= rom_word(rom_address);

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_addrs();
    for (int i = 0; i < 4; i++) bus.addr[i*11 +: 11] = a_tab[i];
  endtask

  initial begin
    a_tab[0] = 11'd100; a_tab[1] = 11'd205; a_tab[2] = 11'd310; a_tab[3] = 11'd415;
    set_addrs();
    rst = 1'b1;
    bus.req = '0;
    step();

    // reset held three cycles with every requester asking
    bus.req = 4'b1111;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("rst_gnt", bus.gnt, 0);
      check("rst_addr", rom_address, 0);
      check("rst_rvalid", bus.rvalid, 0);
      check("rst_rdata", bus.rdata, 0);
      step();
    end
    rst = 1'b0;

`ifdef SPRITE_ARB_FIXED_PRIO_EN
    #1;
    check("fx_first_gnt", bus.gnt, 4'b0001);
    step();
    bus.req = 4'b0110;
    for (int c = 0; c < 4; c++) begin
      #1;
      check("fx_gnt", bus.gnt, 4'b0010);
      check("fx_addr", rom_address, a_tab[1]);
      if (c >= 2) begin
        check("fx_rvalid", bus.rvalid, 4'b0010);
        check("fx_rdata", bus.rdata, rom_word(a_tab[1]));
      end
      step();
    end
    bus.req = '0;
`else
    for (int c = 0; c < 8; c++) begin
      #1;
      check("rr_gnt", bus.gnt, 32'(1) << (c % 4));
      check("rr_addr", rom_address, a_tab[c % 4]);
      if (c >= 2) begin
        check("rr_rvalid", bus.rvalid, 32'(1) << ((c - 2) % 4));
        check("rr_rdata", bus.rdata, rom_word(a_tab[(c - 2) % 4]));
      end else begin
        check("rr_rvalid_early", bus.rvalid, 0);
      end
      step();
    end
    bus.req = '0;
    #1;
    check("drain_gnt", bus.gnt, 0);
    check("drain_rv2", bus.rvalid, 4'b0100);
    check("drain_rd2", bus.rdata, rom_word(a_tab[2]));
    step();
    check("drain_rv3", bus.rvalid, 4'b1000);
    check("drain_rd3", bus.rdata, rom_word(a_tab[3]));
    step();
    check("drain_rv_idle", bus.rvalid, 0);
    step();

    // skip and wrap from last index 3, idle cycle in between
    bus.req = 4'b1010;
    #1;
    check("sw_gnt0", bus.gnt, 4'b0010);
    check("sw_addr0", rom_address, a_tab[1]);
    step();
    check("sw_gnt1", bus.gnt, 4'b1000);
    check("sw_addr1", rom_address, a_tab[3]);
    step();
    bus.req = '0;
    #1;
    check("sw_idle_gnt", bus.gnt, 0);
    check("sw_idle_addr", rom_address, 0);
    check("sw_rv0", bus.rvalid, 4'b0010);
    check("sw_rd0", bus.rdata, rom_word(a_tab[1]));
    step();
    bus.req = 4'b1010;
    #1;
    check("sw_gnt2", bus.gnt, 4'b0010);
    check("sw_rv1", bus.rvalid, 4'b1000);
    check("sw_rd1", bus.rdata, rom_word(a_tab[3]));
    step();
    bus.req = '0;
    #1;
    check("sw_rv_gap", bus.rvalid, 0);
    step();
    check("sw_rv2", bus.rvalid, 4'b0010);
    check("sw_rd2", bus.rdata, rom_word(a_tab[1]));
    step();

    // single requester, address 37 -> word 9
    a_tab[2] = 11'd37;
    set_addrs();
    bus.req = 4'b0100;
    #1;
    check("single_gnt", bus.gnt, 4'b0100);
    check("single_addr", rom_address, 37);
    step();
    bus.req = '0;
    #1;
    check("single_rv_n1", bus.rvalid, 0);
    step();
    check("single_rv", bus.rvalid, 4'b0100);
    check("single_rd", bus.rdata, 9);
    step();

    // reset while index 1 is in flight
    bus.req = 4'b0010;
    #1;
    check("mf_gnt", bus.gnt, 4'b0010);
    step();
    rst = 1'b1;
    bus.req = '0;
    #1;
    check("mf_rst_gnt", bus.gnt, 0);
    step();
    rst = 1'b0;
    bus.req = 4'b1111;
    #1;
    check("mf_no_rv", bus.rvalid, 0);
    check("mf_rdata_clr", bus.rdata, 0);
    check("mf_gnt_after", bus.gnt, 4'b0001);
    check("mf_addr_after", rom_address, a_tab[0]);
    step();
    bus.req = '0;
    #1;
    check("mf_rv_n1", bus.rvalid, 0);
    step();
    check("mf_rv", bus.rvalid, 4'b0001);
    check("mf_rd", bus.rdata, rom_word(a_tab[0]));
    step();
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sprite_rom_arbiter.md
# sprite_rom_arbiter

- Shares one sprite ROM read port among up to NUM_REQ sprite mappers (snake head/body variants, fruit, tiles). Each mapper already has a ROM address computed from DrawX/DrawY.
- The block picks one requester per vga_clk cycle, round-robin, and drives the shared ROM address.
- It tracks the ROM read latency with a one-hot tag pipeline and returns each palette index to the requester that issued it.
- It sits between the per-sprite mappers and a single `*_rom` instance, ahead of the palette lookup.

## Interface
Parameters:
- NUM_REQ, 4, number of requesters (2..8)
- ADDR_W, 11, ROM address width
- DATA_W, 5, ROM word width (palette index)
- ROM_LAT, 1, ROM read latency in cycles (1..3)

Ports:
- vga_clk  in  1  sole clock; all state on posedge
- reset  in  1  synchronous, active-high
- req  in  NUM_REQ  per-requester read request, level
- addr  in  NUM_REQ*ADDR_W  request addresses; requester i at bits [i*ADDR_W +: ADDR_W]
- gnt  out  NUM_REQ  one-hot grant, combinational; the request is accepted in this cycle
- rom_address  out  ADDR_W  address to the shared ROM, combinational
- rom_q  in  DATA_W  ROM data, valid ROM_LAT cycles after the address
- rvalid  out  NUM_REQ  one-hot, registered; marks the requester whose data is on rdata
- rdata  out  DATA_W  registered ROM word

## Operation
- Grants:
  - At most one gnt bit is high per cycle.
  - gnt is all-zero when req is all-zero or reset is high.
- rom_address:
  - Equals addr of the granted requester.
  - Equals 0 when there is no grant.
- Round-robin state:
  - last_idx (log2 NUM_REQ bits) holds the most recently granted index.
  - Priority order is last_idx+1, last_idx+2, …, wrapping modulo NUM_REQ; last_idx itself has lowest priority.
  - last_idx updates on the clock edge only in cycles with a grant. Idle cycles leave it unchanged.
  - Reset value is NUM_REQ-1, so requester 0 has top priority after reset.
- Tag pipeline:
  - ROM_LAT stages, each NUM_REQ bits wide.
  - Stage 0 loads gnt; each later stage shifts forward every cycle with no stall.
  - On the edge where the final stage is nonzero, rdata <= rom_q and rvalid <= final stage.
  - Otherwise rvalid <= 0 and rdata holds its value.
- Requesters hold req and addr until they see gnt. They must not change addr in the grant cycle.
- The arbiter drops no request and duplicates no response. Every grant produces exactly one rvalid pulse on the same bit.
- A requester may request back-to-back. It is granted again only after the other active requesters have each been served once.

## Timing
- Grant: same cycle as req (combinational).
- Response: rvalid and rdata appear ROM_LAT+1 edges after the grant edge. Default: grant in cycle n, data in cycle n+2.
- Throughput: one grant per cycle, i.e. 100% port utilisation whenever any req is high.
- Reset values:
  - gnt = 0, rom_address = 0, rvalid = 0, rdata = 0.
  - last_idx = NUM_REQ-1; all tag stages = 0.
- Reset mid-operation:
  - The tag pipeline clears, so in-flight reads are discarded with no rvalid pulse.
  - Requesters must reissue.
- Simultaneous events: a new grant while tags are in flight is normal pipelining and causes no conflict, since stages are independent.
- Out-of-range indices: unused bits of NUM_REQ never appear because last_idx wraps modulo NUM_REQ. This matters when NUM_REQ is not a power of two.

## Configuration
- SPRITE_ARB_FIXED_PRIO_EN
  - Defined: fixed priority; the lowest requester index with req high always wins. last_idx is not implemented.
  - Undefined (default): round-robin as described above.
  - The tag pipeline and response path are identical in both modes.

## Test plan
- Reset: hold reset 3 cycles with req=4'b1111 → gnt=0, rvalid=0, rdata=0 throughout. First grant after release is gnt=4'b0001.
- Single requester: req=4'b0100, addr[2]=11'd37, ROM word 37 = 5'd9 → gnt=4'b0100 in cycle n; rom_address=37; rvalid=4'b0100, rdata=9 in cycle n+2.
- Round-robin: req=4'b1111 held 8 cycles → gnt sequence 0001,0010,0100,1000,0001,… Each rvalid matches its grant delayed 2 cycles, with the correct ROM word.
- Skip and wrap: last grant was index 3, then req=4'b1010 → next grants are 0010, 1000, 0010. Idle cycles between them do not advance the order.
- Mid-flight reset: grant index 1 in cycle n, assert reset in cycle n+1 → no rvalid pulse at n+2; after release, index 0 has priority.
- With SPRITE_ARB_FIXED_PRIO_EN defined: req=4'b0110 held 4 cycles → gnt=0010 every cycle; index 2 is starved, as expected.
